cond_move_wb_pipe: RTL

// - Consumer side of the MOVZ/MOVN zero test. Takes a conditional-move instruction at the
//   E stage and evaluates the condition internally: rt==0 for MOVZ, rt!=0 for MOVN.
// - Carries the resolved write through M and W pipeline registers, with stall and flush.
// - Drives the GRF write port and the M-stage forwarding bus. Counts suppressed writes.

---
 rtl/cond_move_wb_pipe.sv | 121 ++++++++++++
 1 files changed

// File: rtl/cond_move_wb_pipe.sv
// Conditional-move (MOVZ/MOVN) write-back pipe: resolves the move condition at E and
// carries the resolved write through the M and W registers to the GRF and forwarding bus.
module cond_move_wb_pipe #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic              e_valid,
   input  logic              e_op_movz,
   input  logic              e_op_movn,
   input  logic [DATA_W-1:0] e_rs_data,
   input  logic [DATA_W-1:0] e_rt_data,
   input  logic [ADDR_W-1:0] e_rd_addr,
   output logic              fwd_m_we,
   output logic [ADDR_W-1:0] fwd_m_addr,
   output logic [DATA_W-1:0] fwd_m_data,
   output logic              w_we,
   output logic [ADDR_W-1:0] w_addr,
   output logic [DATA_W-1:0] w_data,
   output logic              illegal_op,
   output logic [CNT_W-1:0]  supp_cnt
);

   typedef struct packed {
      logic              valid;
      logic              we;
      logic              cm;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } slot_t;

   slot_t             e_slot;
   slot_t             m_q, m_d;
   slot_t             w_q, w_d;
   logic              illegal_q, illegal_d;
   logic [CNT_W-1:0]  supp_q, supp_d;

   logic              both_ops;
   logic              cond;
   logic              retire_fail;

   // Both op bits together is an encoding error: never write, but still a cond-move slot.
   assign both_ops = e_op_movz & e_op_movn;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      cond = 1'b0;
      if (!both_ops) begin
         if (e_op_movz)      cond = (e_rt_data == '0);
         else if (e_op_movn) cond = (e_rt_data != '0);
      end
   end

   always_comb begin
      e_slot.valid = e_valid;
      e_slot.we    = e_valid & cond & (e_rd_addr != '0);
      e_slot.cm    = e_valid & (e_op_movz | e_op_movn);
      e_slot.addr  = e_rd_addr;
      e_slot.data  = e_rs_data;
   end

   // Stall dominates flush; a flush raised during a stall is dropped, not deferred.
   always_comb begin
      m_d = m_q;
      if (!stall) begin
         if (flush) begin
            m_d.valid = 1'b0;
            m_d.we    = 1'b0;
            m_d.cm    = 1'b0;
         end else begin
            m_d = e_slot;
         end
      end
   end

   always_comb begin
      w_d = w_q;
      if (!stall) w_d = m_q;
   end

   // A failed move is counted once, on the edge where it leaves W.
   assign retire_fail = ~stall & w_q.valid & w_q.cm & ~w_q.we;

   always_comb begin
      supp_d = supp_q;
      if (retire_fail && !(&supp_q)) supp_d = supp_q + CNT_W'(1);
   end

   assign illegal_d = illegal_q | (e_valid & both_ops);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         m_q       <= '0;
         w_q       <= '0;
         illegal_q <= 1'b0;
         supp_q    <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         m_q       <= m_d;
         w_q       <= w_d;
         illegal_q <= illegal_d;
         supp_q    <= supp_d;
      end
   end

   assign fwd_m_we   = m_q.valid & m_q.we;
   assign fwd_m_addr = m_q.addr;
   assign fwd_m_data = m_q.data;

   assign w_we       = w_q.valid & w_q.we;
   assign w_addr     = w_q.addr;
   assign w_data     = w_q.data;

   assign illegal_op = illegal_q;
   assign supp_cnt   = supp_q;

endmodule
